ula_rpn_ctrl: RTL and testbench

RPN sequencer for the 8-bit ULA. Holds a small operand stack and sequences the shared 8-bit ripple-carry adder (`somador8x8`, instanced in the parent) for ADD, SUB and a shift-add MUL. The result is written back to the top of the stack. The adder stays purely combinational; all operand muxing and iteration control live here.

---
 rtl/ula_rpn_pkg.sv | 13 +
 rtl/ula_rpn_ctrl_if.sv | 34 +++
 rtl/rpn_stack.sv | 44 ++++
 rtl/ula_rpn_ctrl.sv | 143 ++++++++++++++
 tb/tb_ula_rpn_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ula_rpn_pkg.sv
// Shared encodings for the ULA RPN sequencer: op codes and controller states.
package ula_rpn_pkg;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10
   } state_t;
endpackage

// File: rtl/ula_rpn_ctrl_if.sv
// Command, status and adder-port bundle between the RPN controller and its parent.
interface ula_rpn_ctrl_if #(
   parameter int DEPTH = 4,
   parameter int W     = 8
);
   import ula_rpn_pkg::*;

   logic                         push;
   logic [W-1:0]                 din;
   logic                         op_valid;
   logic [1:0]                   op;
   logic                         busy;
   logic                         res_valid;
   logic                         flag;
   logic                         err;
   logic [W-1:0]                 top;
   logic [$clog2(DEPTH+1)-1:0]   depth;
   logic [W-1:0]                 add_a;
   logic [W-1:0]                 add_b;
   logic                         add_cin;
   logic [W-1:0]                 add_s;
   logic                         add_co;
   state_t                       dbg_state;

   modport master (
      output push, din, op_valid, op, add_s, add_co,
      input  busy, res_valid, flag, err, top, depth, add_a, add_b, add_cin, dbg_state
   );

   modport slave (
      input  push, din, op_valid, op, add_s, add_co,
      output busy, res_valid, flag, err, top, depth, add_a, add_b, add_cin, dbg_state
   );
endinterface

// File: rtl/rpn_stack.sv
// Shift-register LIFO: entry 0 is the top; unused entries are kept at zero.
module rpn_stack #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop2_push1,
   input  logic                       clear,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               t,
   output logic [W-1:0]               n,
   output logic [$clog2(DEPTH+1)-1:0] depth
);
   localparam int DW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [DW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         cnt <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         cnt <= '0;
      end else if (pop2_push1) begin
         // Result replaces T and N; everything below moves up one slot.
         mem[0] <= wdata;
         for (int i = 1; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
         mem[DEPTH-1] <= '0;
         cnt <= cnt - 1'b1;
      end else if (push && cnt != DW'(DEPTH)) begin
         mem[0] <= wdata;
         for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
         cnt <= cnt + 1'b1;
      end
   end

   assign t     = mem[0];
   assign n     = mem[1];
   assign depth = cnt;
endmodule

// File: rtl/ula_rpn_ctrl.sv
// RPN sequencer: drives an external combinational adder for ADD, SUB and shift-add MUL.
module ula_rpn_ctrl
   import ula_rpn_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input logic           clk,
   input logic           rst,
   ula_rpn_ctrl_if.slave bus
);
   localparam int DW = $clog2(DEPTH+1);
   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t        state;
   logic          is_sub;
   logic [W-1:0]  acc, mcand, mplr;
   logic          ovf;
   logic [CW-1:0] cnt;
   logic          busy_q, res_valid_q, flag_q, err_q;

   logic          st_push, st_pop2, st_clear;
   logic [W-1:0]  st_wdata, t, n;
   logic [DW-1:0] sdepth;
   logic          full, enough, mul_last, mul_ovf;

   rpn_stack #(.DEPTH(DEPTH), .W(W)) u_stack (
      .clk(clk), .rst(rst), .push(st_push), .pop2_push1(st_pop2), .clear(st_clear),
      .wdata(st_wdata), .t(t), .n(n), .depth(sdepth)
   );

   assign full     = (sdepth == DW'(DEPTH));
   assign enough   = (sdepth >= DW'(2));
   assign mul_last = (cnt == CW'(W - 1));
   assign mul_ovf  = ovf | (mplr[0] & bus.add_co) | (mcand[W-1] & (|(mplr >> 1)));

   always_comb begin
      st_push     = 1'b0;
      st_pop2     = 1'b0;
      st_clear    = 1'b0;
      st_wdata    = bus.din;
      bus.add_a   = '0;
      bus.add_b   = '0;
      bus.add_cin = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.op_valid) st_clear = (bus.op == OP_CLR);
            else              st_push  = bus.push && !full;
         end
         ST_EXEC: begin
            bus.add_a   = n;
            bus.add_b   = is_sub ? ~t : t;
            bus.add_cin = is_sub;
            st_pop2     = 1'b1;
            st_wdata    = bus.add_s;
         end
         ST_MUL: begin
            bus.add_a = acc;
            bus.add_b = mcand;
            st_pop2   = mul_last;
            st_wdata  = mplr[0] ? bus.add_s : acc;
         end
         default: ;
      endcase
   end

   // A command is taken only when busy is low; push/op_valid while busy, or a
   // command the stack cannot satisfy, is rejected with a one-cycle err pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         is_sub      <= 1'b0;
         acc         <= '0;
         mcand       <= '0;
         mplr        <= '0;
         ovf         <= 1'b0;
         cnt         <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         flag_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.op_valid) begin
                  if (bus.push) err_q <= 1'b1;
                  if (bus.op != OP_CLR) begin
                     if (!enough) begin
                        err_q <= 1'b1;
                     end else if (bus.op == OP_MUL) begin
                        state  <= ST_MUL;
                        busy_q <= 1'b1;
                        acc    <= '0;
                        mcand  <= n;
                        mplr   <= t;
                        ovf    <= 1'b0;
                        cnt    <= '0;
                     end else begin
                        state  <= ST_EXEC;
                        busy_q <= 1'b1;
                        is_sub <= (bus.op == OP_SUB);
                     end
                  end
               end else if (bus.push && full) begin
                  err_q <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (bus.push || bus.op_valid) err_q <= 1'b1;
               state       <= ST_IDLE;
               busy_q      <= 1'b0;
               res_valid_q <= 1'b1;
               flag_q      <= is_sub ? ~bus.add_co : bus.add_co;
            end
            ST_MUL: begin
               if (bus.push || bus.op_valid) err_q <= 1'b1;
               if (mplr[0]) acc <= bus.add_s;
               ovf   <= mul_ovf;
               mcand <= mcand << 1;
               mplr  <= mplr >> 1;
               cnt   <= cnt + 1'b1;
               if (mul_last) begin
                  state       <= ST_IDLE;
                  busy_q      <= 1'b0;
                  res_valid_q <= 1'b1;
                  flag_q      <= mul_ovf;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.res_valid = res_valid_q;
   assign bus.flag      = flag_q;
   assign bus.err       = err_q;
   assign bus.top       = t;
   assign bus.depth     = sdepth;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_ula_rpn_ctrl.sv
// Directed bench for ula_rpn_ctrl with a behavioural 8-bit adder standing in for somador8x8.
module tb_ula_rpn_ctrl;
   import ula_rpn_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   ula_rpn_ctrl_if #(.DEPTH(4), .W(8)) bus ();

   ula_rpn_ctrl #(.DEPTH(4), .W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      bus.push = 1'b0; bus.din = '0; bus.op_valid = 1'b0; bus.op = 2'b00;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic push_val(input logic [7:0] v);
      bus.push = 1'b1; bus.din = v;
      @(negedge clk);
      bus.push = 1'b0;
   endtask

   // Leaves the caller at the negedge of the cycle after edge 0.
   task automatic issue_op(input logic [1:0] o);
      bus.op_valid = 1'b1; bus.op = o;
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   // Counts busy cycles (bounded); ends at the first negedge with busy low.
   task automatic wait_idle(output int cyc);
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.push = 1'b0; bus.din = '0; bus.op_valid = 1'b0; bus.op = 2'b00;
      #1;
      n_cmp++; if ({bus.busy, bus.res_valid, bus.flag, bus.err} !== 4'b0000) begin n_err++;
         $display("FAIL reset_status: got %b want 0000", {bus.busy, bus.res_valid, bus.flag, bus.err}); end
      n_cmp++; if (bus.top !== 8'h00 || bus.depth !== 3'd0) begin n_err++;
         $display("FAIL reset_stack: got top=%h depth=%0d want 00/0", bus.top, bus.depth); end
      n_cmp++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 17'd0) begin n_err++;
         $display("FAIL reset_adder: got a=%h b=%h cin=%b want 0", bus.add_a, bus.add_b, bus.add_cin); end
      n_cmp++; if (bus.dbg_state !== ST_IDLE) begin n_err++;
         $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      do_reset();
      push_val(8'h05); push_val(8'h03);
      n_cmp++; if (bus.top !== 8'h03 || bus.depth !== 3'd2) begin n_err++;
         $display("FAIL push_pair: got top=%h depth=%0d want 03/2", bus.top, bus.depth); end
      issue_op(OP_ADD);
      n_cmp++; if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0) begin n_err++;
         $display("FAIL add_busy: got busy=%b rv=%b want 1/0", bus.busy, bus.res_valid); end
      n_cmp++; if (bus.add_a !== 8'h05 || bus.add_b !== 8'h03 || bus.add_cin !== 1'b0) begin n_err++;
         $display("FAIL add_operands: got a=%h b=%h cin=%b want 05/03/0", bus.add_a, bus.add_b, bus.add_cin); end
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.busy !== 1'b0) begin n_err++;
         $display("FAIL add_done: got rv=%b busy=%b want 1/0", bus.res_valid, bus.busy); end
      n_cmp++; if (bus.top !== 8'h08 || bus.depth !== 3'd1 || bus.flag !== 1'b0) begin n_err++;
         $display("FAIL add_result: got top=%h depth=%0d flag=%b want 08/1/0", bus.top, bus.depth, bus.flag); end
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b0 || {bus.add_a, bus.add_b} !== 16'h0000) begin n_err++;
         $display("FAIL add_idle_after: got rv=%b a=%h b=%h want 0/00/00", bus.res_valid, bus.add_a, bus.add_b); end
   endtask

   task automatic test_carry_borrow();
      int cyc;
      do_reset();
      push_val(8'hF0); push_val(8'h20);
      issue_op(OP_ADD);
      wait_idle(cyc);
      n_cmp++; if (bus.top !== 8'h10 || bus.flag !== 1'b1 || bus.res_valid !== 1'b1) begin n_err++;
         $display("FAIL add_carry: got top=%h flag=%b rv=%b want 10/1/1", bus.top, bus.flag, bus.res_valid); end
      push_val(8'h03); push_val(8'h05);
      issue_op(OP_SUB);
      n_cmp++; if (bus.add_a !== 8'h03 || bus.add_b !== 8'hFA || bus.add_cin !== 1'b1) begin n_err++;
         $display("FAIL sub_operands: got a=%h b=%h cin=%b want 03/FA/1", bus.add_a, bus.add_b, bus.add_cin); end
      wait_idle(cyc);
      n_cmp++; if (bus.top !== 8'hFE || bus.flag !== 1'b1 || bus.depth !== 3'd2) begin n_err++;
         $display("FAIL sub_borrow: got top=%h flag=%b depth=%0d want FE/1/2", bus.top, bus.flag, bus.depth); end
      push_val(8'h09); push_val(8'h04);
      issue_op(OP_SUB);
      wait_idle(cyc);
      n_cmp++; if (bus.top !== 8'h05 || bus.flag !== 1'b0 || bus.depth !== 3'd3) begin n_err++;
         $display("FAIL sub_noborrow: got top=%h flag=%b depth=%0d want 05/0/3", bus.top, bus.flag, bus.depth); end
   endtask

   task automatic test_mul();
      int cyc;
      do_reset();
      push_val(8'h0C); push_val(8'h0B);
      issue_op(OP_MUL);
      n_cmp++; if (bus.dbg_state !== ST_MUL) begin n_err++;
         $display("FAIL mul_state: got %0d want %0d", bus.dbg_state, ST_MUL); end
      wait_idle(cyc);
      n_cmp++; if (cyc !== 8) begin n_err++;
         $display("FAIL mul_busy_len: got %0d want 8", cyc); end
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.top !== 8'h84 || bus.flag !== 1'b0 || bus.depth !== 3'd1) begin n_err++;
         $display("FAIL mul_result: got rv=%b top=%h flag=%b depth=%0d want 1/84/0/1", bus.res_valid, bus.top, bus.flag, bus.depth); end
      push_val(8'h10); push_val(8'h10);
      issue_op(OP_MUL);
      wait_idle(cyc);
      n_cmp++; if (cyc !== 8 || bus.top !== 8'h00 || bus.flag !== 1'b1 || bus.depth !== 3'd2) begin n_err++;
         $display("FAIL mul_ovf: got cyc=%0d top=%h flag=%b depth=%0d want 8/00/1/2", cyc, bus.top, bus.flag, bus.depth); end
   endtask

   // Runs right after test_mul so flag=1 beforehand and must survive CLR.
   task automatic test_clr();
      issue_op(OP_CLR);
      n_cmp++; if (bus.depth !== 3'd0 || bus.top !== 8'h00) begin n_err++;
         $display("FAIL clr_stack: got depth=%0d top=%h want 0/00", bus.depth, bus.top); end
      n_cmp++; if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.flag !== 1'b1 || bus.err !== 1'b0) begin n_err++;
         $display("FAIL clr_status: got busy=%b rv=%b flag=%b err=%b want 0/0/1/0", bus.busy, bus.res_valid, bus.flag, bus.err); end
   endtask

   task automatic test_errors();
      do_reset();
      push_val(8'h01); push_val(8'h02); push_val(8'h03); push_val(8'h04);
      push_val(8'h05);
      n_cmp++; if (bus.err !== 1'b1 || bus.depth !== 3'd4 || bus.top !== 8'h04) begin n_err++;
         $display("FAIL push_full: got err=%b depth=%0d top=%h want 1/4/04", bus.err, bus.depth, bus.top); end
      @(negedge clk);
      n_cmp++; if (bus.err !== 1'b0) begin n_err++;
         $display("FAIL err_pulse_len: got %b want 0", bus.err); end
      do_reset();
      push_val(8'h07);
      issue_op(OP_ADD);
      n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.depth !== 3'd1 || bus.top !== 8'h07) begin n_err++;
         $display("FAIL add_underflow: got err=%b busy=%b depth=%0d top=%h want 1/0/1/07", bus.err, bus.busy, bus.depth, bus.top); end
      do_reset();
      push_val(8'h02); push_val(8'h03);
      bus.push = 1'b1; bus.din = 8'h99;
      issue_op(OP_ADD);
      bus.push = 1'b0;
      n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b1) begin n_err++;
         $display("FAIL push_op_clash: got err=%b busy=%b want 1/1", bus.err, bus.busy); end
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.top !== 8'h05 || bus.depth !== 3'd1) begin n_err++;
         $display("FAIL clash_result: got rv=%b top=%h depth=%0d want 1/05/1", bus.res_valid, bus.top, bus.depth); end
   endtask

   task automatic test_push_during_mul();
      int cyc;
      do_reset();
      push_val(8'h03); push_val(8'h06);
      issue_op(OP_MUL);
      @(negedge clk); @(negedge clk);
      push_val(8'hAA);
      n_cmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b1 || bus.depth !== 3'd2) begin n_err++;
         $display("FAIL busy_push: got err=%b busy=%b depth=%0d want 1/1/2", bus.err, bus.busy, bus.depth); end
      wait_idle(cyc);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.top !== 8'h12 || bus.flag !== 1'b0 || bus.depth !== 3'd1) begin n_err++;
         $display("FAIL mul_after_push: got rv=%b top=%h flag=%b depth=%0d want 1/12/0/1", bus.res_valid, bus.top, bus.flag, bus.depth); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      push_val(8'h01); push_val(8'h02); push_val(8'h03);
      issue_op(OP_ADD);
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.top !== 8'h05) begin n_err++;
         $display("FAIL b2b_first: got rv=%b top=%h want 1/05", bus.res_valid, bus.top); end
      issue_op(OP_ADD);
      n_cmp++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin n_err++;
         $display("FAIL b2b_accept: got busy=%b err=%b want 1/0", bus.busy, bus.err); end
      @(negedge clk);
      n_cmp++; if (bus.res_valid !== 1'b1 || bus.top !== 8'h06 || bus.depth !== 3'd1) begin n_err++;
         $display("FAIL b2b_second: got rv=%b top=%h depth=%0d want 1/06/1", bus.res_valid, bus.top, bus.depth); end
   endtask

   task automatic test_rst_mid_mul();
      int seen;
      do_reset();
      push_val(8'h0C); push_val(8'h0B);
      issue_op(OP_MUL);
      @(negedge clk); @(negedge clk); @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.busy !== 1'b0 || bus.depth !== 3'd0 || bus.top !== 8'h00 || bus.dbg_state !== ST_IDLE) begin n_err++;
         $display("FAIL rst_abort: got busy=%b depth=%0d top=%h state=%0d want 0/0/00/0", bus.busy, bus.depth, bus.top, bus.dbg_state); end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.res_valid === 1'b1) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_err++;
         $display("FAIL rst_no_result: got %0d res_valid pulses want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry_borrow();
      test_mul();
      test_clr();
      test_errors();
      test_push_during_mul();
      test_back_to_back();
      test_rst_mid_mul();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
